shift_chain_ctrl: RTL and testbench

- Sequencer for a chain of WIDTH D flip-flops used as a parallel-in/serial-out register.
- Accepts a parallel word over a valid/ready handshake and loads it into an internal shift register.
- Shifts the word out one bit per accepted beat, MSB first, with a last-beat flag.
- Drives load/shift strobes so an external gate-level DFF chain can be run in lockstep with it.

---
 rtl/shift_chain_ctrl.sv | 127 ++++++++++++
 tb/tb_shift_chain_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_ctrl.sv
// Parallel-in/serial-out sequencer with load/shift strobes for a DFF chain.
// Optional parity beat: define SHIFT_CHAIN_PARITY_EN.
module shift_chain_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy,
  output logic             chain_load,
  output logic             chain_shift
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

`ifdef SHIFT_CHAIN_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             load_q, load_d;
  logic             shift_q, shift_d;
  logic             capture, beat, at_last, data_bit;

`ifdef SHIFT_CHAIN_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(WIDTH);
  logic par_q, par_d;

  // Parity of the captured word, held for the trailing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  // Parity is latched together with the word.
  always_comb begin
    par_d = par_q;
    if (capture) par_d = ^in_data;
  end

  assign data_bit = (cnt_q == PAR_CNT) ? par_q : sreg_q[WIDTH-1];
`else
  assign data_bit = sreg_q[WIDTH-1];
`endif

  assign sout_valid  = (state_q == SHIFT);
  assign busy        = sout_valid;
  assign sout        = sout_valid & data_bit;
  assign at_last     = sout_valid & (cnt_q == LAST_CNT);
  assign sout_last   = at_last;
  assign in_ready    = in_ready_q;
  assign chain_load  = load_q;
  assign chain_shift = shift_q;
  assign capture     = (state_q == IDLE) & in_valid & in_ready_q;
  assign beat        = sout_valid & sout_ready;

  // Next-state logic for the sequencer and the shift register.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    load_d     = capture;
    shift_d    = beat;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (capture) begin
          sreg_d     = in_data;
          cnt_d      = '0;
          state_d    = SHIFT;
          in_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        in_ready_d = 1'b0;
        if (beat) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
          if (at_last) begin
            state_d    = IDLE;
            cnt_d      = '0;
            in_ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      load_q     <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      load_q     <= load_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Scoreboard bench for shift_chain_ctrl.
// Expected beats are derived from each handshaken word.
module tb_shift_chain_ctrl;
  localparam int W = 8;
`ifdef SHIFT_CHAIN_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 0, rst_n = 0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 0, sout_ready = 0;
  logic in_ready, sout, sout_valid, sout_last, busy;
  logic chain_load, chain_shift;

  shift_chain_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .sout(sout), .sout_valid(sout_valid),
    .sout_ready(sout_ready), .sout_last(sout_last),
    .busy(busy), .chain_load(chain_load),
    .chain_shift(chain_shift)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [1:0] exp_q[$];
  int n_acc = 0, cyc = 0;
  int cap_cyc[$];
  int rdy_mode = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: MSB-first bits, optional even-parity beat, last flag.
  task automatic push_word(logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--)
      exp_q.push_back({w[i], (i == 0) && !PAR});
    if (PAR) exp_q.push_back({^w, 1'b1});
  endtask

  // Consumer ready: 0 tied high, 1 pattern 1,0,0,1, 2 random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: sout_ready = 1'b1;
      1: sout_ready = (cyc % 3) == 0;
      default: sout_ready = $urandom_range(0, 1);
    endcase
  end

  // Monitor: compares beats, stability and strobes at negedge.
  logic prev_acc = 0, prev_hs = 0, prev_hold = 0;
  logic prev_sout = 0, prev_last = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_acc = 0; prev_hs = 0; prev_hold = 0;
    end else begin
      chk("chain_load", chain_load, prev_hs);
      chk("chain_shift", chain_shift, prev_acc);
      if (prev_hs) cap_cyc.push_back(cyc);
      if (prev_hold) begin
        chk("hold_valid", sout_valid, 1);
        chk("hold_sout", sout, prev_sout);
        chk("hold_last", sout_last, prev_last);
      end
      if (sout_valid && sout_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("sout", sout, e[1]);
          chk("sout_last", sout_last, e[0]);
        end
      end
      prev_acc  = sout_valid && sout_ready;
      prev_hs   = in_valid && in_ready;
      prev_hold = sout_valid && !sout_ready;
      prev_sout = sout;
      prev_last = sout_last;
    end
  end

  // Offer a word; keep_valid leaves in_valid high afterwards.
  task automatic send(logic [W-1:0] w, bit keep_valid);
    int t;
    @(posedge clk); #1;
    in_data = w; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 200) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    push_word(w);
    @(posedge clk); #1;
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 || busy) begin
      @(negedge clk);
      if (++t > 2000) begin
        chk("drain_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_sout"}, sout, 0);
    chk({tag, "_sout_valid"}, sout_valid, 0);
    chk({tag, "_sout_last"}, sout_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobes"}, {chain_load, chain_shift}, 0);
  endtask

  initial begin
    int base, t, gap;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    chk("busy_after_rst", busy, 0);

    send(8'hA5, 0);
    drain();
    chk("in_ready_after_word", in_ready, 1);

    rdy_mode = 1;
    base = n_acc;
    send(8'h3C, 0);
    drain();
    chk("accepts_3c", n_acc - base, PAR ? W + 1 : W);

    rdy_mode = 0;
    cap_cyc.delete();
    send(8'hFF, 1);
    send(8'h01, 0);
    drain();
    gap = (cap_cyc.size() == 2) ? cap_cyc[1] - cap_cyc[0] : -1;
    chk("b2b_gap", gap, PAR ? W + 2 : W + 1);

    base = n_acc;
    send(8'hF0, 0);
    t = 0;
    while (n_acc < base + 3 && t < 100) begin
      @(negedge clk); t++;
    end
    chk("three_beats", n_acc - base, 3);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk_reset_outs("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    send(8'h81, 0);
    drain();

    send(8'h07, 0);
    send(8'h03, 0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(W'($urandom), $urandom_range(0, 1));
    end
    in_valid = 1'b0;
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
